// File: rtl/btest_pkg.sv
// Shared definitions for the BtestIndication pipe messages, used by both the
// method-to-pipe marshaller and the pipe-to-method demarshaller.
package btest_pkg;

  localparam int BTEST_HEARD_ID  = 5;
  localparam int RSV_W           = 16;
  localparam int ID_W            = 16;
  localparam int PAD_W           = 64;
  localparam int WLEN_W          = 16;
  localparam int HEARD_PAYLOAD_W = 64;

  // Field order is MSB first; the payload sits directly above pad and wlen.
  typedef struct packed {
    logic [RSV_W-1:0]           rsv;
    logic [ID_W-1:0]            id;
    logic [HEARD_PAYLOAD_W-1:0] payload;
    logic [PAD_W-1:0]           pad;
    logic [WLEN_W-1:0]          wlen;
  } btest_heard_msg_t;

endpackage

// File: rtl/p2m_btest_indication_if.sv
// Pipe-in and heard-out handshake bundle for the BtestIndication demarshaller.
interface p2m_btest_indication_if #(
  parameter int PAYLOAD_W = 64,
  parameter int ERR_W     = 8
);
  localparam int MSG_W = 112 + PAYLOAD_W;

  logic             pipe_enq_ena;
  logic [MSG_W-1:0] pipe_enq_v;
  logic             pipe_enq_rdy;
  logic             heard_ena;
  logic [PAYLOAD_W-1:0] heard_v;
  logic             heard_rdy;
  logic [ERR_W-1:0] err_count;
  logic             err_sticky;

  modport master (
    output pipe_enq_ena, pipe_enq_v, heard_rdy,
    input  pipe_enq_rdy, heard_ena, heard_v, err_count, err_sticky
  );

  modport slave (
    input  pipe_enq_ena, pipe_enq_v, heard_rdy,
    output pipe_enq_rdy, heard_ena, heard_v, err_count, err_sticky
  );
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO with toggling pointers; the read data reads as zero when empty.
module skid_fifo2 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq,
  output logic [WIDTH-1:0] deq_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_q [2];
  logic [WIDTH-1:0] mem_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      mem_d[wr_ptr_q] = enq_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (deq) rd_ptr_d = ~rd_ptr_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left unreset; count gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign deq_data = (count_q != 2'd0) ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/p2m_btest_indication.sv
// BtestIndication demarshaller: checks pipe message headers, buffers valid
// payloads two deep and replays them as heard invocations; bad messages are counted.
module p2m_btest_indication
  import btest_pkg::*;
#(
  parameter int PAYLOAD_W = 64,
  parameter int METHOD_ID = BTEST_HEARD_ID,
  parameter int ERR_W     = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  p2m_btest_indication_if.slave  bus
);

  localparam int MSG_W = 112 + PAYLOAD_W;

  logic [RSV_W-1:0]     rsv;
  logic [ID_W-1:0]      id;
  logic [WLEN_W-1:0]    wlen;
  logic [PAYLOAD_W-1:0] payload;
  logic                 hdr_ok;
  logic                 accept;
  logic                 deq;
  logic [1:0]           fifo_count;
  logic [ERR_W-1:0]     err_count_q, err_count_d;
  logic                 err_sticky_q, err_sticky_d;

  assign rsv     = bus.pipe_enq_v[MSG_W-1 -: RSV_W];
  assign id      = bus.pipe_enq_v[MSG_W-17 -: ID_W];
  assign payload = bus.pipe_enq_v[80 +: PAYLOAD_W];
  assign wlen    = bus.pipe_enq_v[WLEN_W-1:0];

  assign hdr_ok = (rsv == '0) && (id == ID_W'(METHOD_ID)) && (wlen == WLEN_W'(PAYLOAD_W));

  // Ready depends on buffer occupancy only, never on heard_rdy.
  assign bus.pipe_enq_rdy = (fifo_count != 2'd2);
  assign accept           = bus.pipe_enq_ena && bus.pipe_enq_rdy;
  assign deq              = (fifo_count != 2'd0) && bus.heard_rdy;
  assign bus.heard_ena    = deq;

  skid_fifo2 #(.WIDTH(PAYLOAD_W)) u_fifo (
    .clk      (CLK),
    .rst      (RST),
    .enq      (accept && hdr_ok),
    .enq_data (payload),
    .deq      (deq),
    .deq_data (bus.heard_v),
    .count    (fifo_count)
  );

  always_comb begin
    err_count_d  = err_count_q;
    err_sticky_d = err_sticky_q;
    if (accept && !hdr_ok) begin
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
      err_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_count_q  <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      err_count_q  <= err_count_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.err_count  = err_count_q;
  assign bus.err_sticky = err_sticky_q;

  // The sender must never present a message while the buffer is full.
  enq_when_full_a: assert property (@(posedge CLK) disable iff (RST)
    !(bus.pipe_enq_ena && !bus.pipe_enq_rdy));

endmodule

// File: tb/tb_p2m_btest_indication.sv
// Scoreboard bench for p2m_btest_indication: valid payloads are queued at send
// time and compared as heard invocations emerge.
module tb_p2m_btest_indication;
  import btest_pkg::*;

  localparam int PAYLOAD_W = 64;
  localparam int ERR_W     = 8;
  localparam int MSG_W     = 112 + PAYLOAD_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  p2m_btest_indication_if #(.PAYLOAD_W(PAYLOAD_W), .ERR_W(ERR_W)) bus ();

  p2m_btest_indication #(.PAYLOAD_W(PAYLOAD_W), .METHOD_ID(5), .ERR_W(ERR_W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [PAYLOAD_W-1:0] exp_q [$];
  int                   dlv_cyc [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] mk(input logic [15:0] rsv, input logic [15:0] id,
                                          input logic [63:0] pl, input logic [15:0] wlen);
    btest_heard_msg_t m;
    m.rsv     = rsv;
    m.id      = id;
    m.payload = pl;
    m.pad     = {$urandom, $urandom};
    m.wlen    = wlen;
    return m;
  endfunction

  always @(posedge clk) cyc++;

  // Monitor: every heard invocation must match the oldest outstanding payload.
  always @(negedge clk) begin
    if (!rst && bus.heard_ena) begin
      if (exp_q.size() == 0) check("unexpected_heard", bus.heard_ena, 0);
      else begin
        check("heard_v", bus.heard_v, exp_q.pop_front());
        dlv_cyc.push_back(cyc);
      end
    end
  end

  // Waits (bounded) for ready, then presents the message for exactly one edge.
  task automatic send(input logic [MSG_W-1:0] m, input bit good);
    int n = 0;
    while (!bus.pipe_enq_rdy && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.pipe_enq_rdy) check("rdy_timeout", bus.pipe_enq_rdy, 1);
    else begin
      bus.pipe_enq_ena = 1'b1;
      bus.pipe_enq_v   = m;
      if (good) exp_q.push_back(m[80 +: PAYLOAD_W]);
      @(posedge clk); #1;
      bus.pipe_enq_ena = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.pipe_enq_ena = 1'b0;
    bus.pipe_enq_v   = '0;
    bus.heard_rdy    = 1'b0;

    // Reset then idle
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", bus.pipe_enq_rdy, 1);
    check("rst_heard_ena", bus.heard_ena, 0);
    check("rst_heard_v", bus.heard_v, 0);
    check("rst_err_count", bus.err_count, 0);
    check("rst_err_sticky", bus.err_sticky, 0);

    // Single valid message: no bypass in the accept cycle, fires the next cycle
    @(posedge clk); #1;
    bus.heard_rdy    = 1'b1;
    bus.pipe_enq_ena = 1'b1;
    bus.pipe_enq_v   = mk(16'h0, 16'd5, 64'hDEADBEEF_01234567, 16'd64);
    exp_q.push_back(64'hDEADBEEF_01234567);
    @(negedge clk);
    check("no_bypass", bus.heard_ena, 0);
    @(posedge clk); #1;
    bus.pipe_enq_ena = 1'b0;
    @(negedge clk);
    check("lat1_ena", bus.heard_ena, 1);
    check("lat1_v", bus.heard_v, 64'hDEADBEEF_01234567);
    idle(2);
    check("single_err", bus.err_count, 0);
    check("single_drain", exp_q.size(), 0);

    // Back-pressure: two accepted, third held off until the consumer drains
    bus.heard_rdy = 1'b0;
    send(mk(16'h0, 16'd5, 64'd1, 16'd64), 1'b1);
    send(mk(16'h0, 16'd5, 64'd2, 16'd64), 1'b1);
    @(negedge clk);
    check("bp_full_rdy", bus.pipe_enq_rdy, 0);
    check("bp_full_ena", bus.heard_ena, 0);
    @(posedge clk); #1;
    dlv_cyc.delete();
    bus.heard_rdy = 1'b1;
    send(mk(16'h0, 16'd5, 64'd3, 16'd64), 1'b1);
    idle(4);
    check("bp_drain", exp_q.size(), 0);
    check("bp_count", dlv_cyc.size(), 3);
    if (dlv_cyc.size() >= 2) check("bp_consecutive", dlv_cyc[1] - dlv_cyc[0], 1);

    // Malformed messages are dropped and counted
    send(mk(16'h0, 16'd6, 64'hBAD0, 16'd64), 1'b0);
    check("bad_id_cnt", bus.err_count, 1);
    check("bad_id_sticky", bus.err_sticky, 1);
    send(mk(16'h0, 16'd5, 64'hBAD1, 16'd32), 1'b0);
    check("bad_wlen_cnt", bus.err_count, 2);
    send(mk(16'h1, 16'd5, 64'hBAD2, 16'd64), 1'b0);
    check("bad_rsv_cnt", bus.err_count, 3);
    send(mk(16'h0, 16'd5, 64'hC0FFEE, 16'd64), 1'b1);
    idle(3);
    check("after_bad_drain", exp_q.size(), 0);
    check("after_bad_sticky", bus.err_sticky, 1);

    // Saturation
    for (int i = 0; i < 300; i++) send(mk(16'h0, 16'd7, 64'(i), 16'd64), 1'b0);
    check("sat_cnt", bus.err_count, 255);
    send(mk(16'hFFFF, 16'd5, 64'h0, 16'd64), 1'b0);
    check("sat_hold", bus.err_count, 255);

    // Reset mid-operation with two entries buffered
    bus.heard_rdy = 1'b0;
    send(mk(16'h0, 16'd5, 64'hAAAA, 16'd64), 1'b1);
    send(mk(16'h0, 16'd5, 64'hBBBB, 16'd64), 1'b1);
    check("mid_full_rdy", bus.pipe_enq_rdy, 0);
    rst = 1'b1;
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rdy", bus.pipe_enq_rdy, 1);
    check("mid_err_count", bus.err_count, 0);
    check("mid_err_sticky", bus.err_sticky, 0);
    @(posedge clk); #1;
    bus.heard_rdy = 1'b1;
    @(negedge clk);
    check("mid_no_stale_ena", bus.heard_ena, 0);
    check("mid_no_stale_v", bus.heard_v, 0);
    idle(3);

    // A fresh message still flows after the mid-operation reset
    send(mk(16'h0, 16'd5, 64'h1234_5678, 16'd64), 1'b1);
    idle(3);
    check("post_rst_drain", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
